// File: rtl/ttl191_load_sequencer_pkg.sv
// ttl191_load_sequencer_pkg: shared widths, state and direction encodings for the 191 load sequencer
// Contents:
//   COUNT_WIDTH  width of the counter data path (one 4-bit counter)
//   seq_state_e  sequencer states: idle, load pulse, counting, done pulse
//   dir_e        counter direction as driven on DOWN_UP_n (1 = down)
package ttl191_load_sequencer_pkg;

    localparam int COUNT_WIDTH = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_LOAD  = 2'd1,
        SEQ_COUNT = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/ttl191_load_sequencer_if.sv
// ttl191_load_sequencer_if: request handshake plus counter pin bundle between timing control and the sequencer
// Signals:
//   start, count, dir_down, abort   request side, driven by the timing control logic
//   rco_n                           ripple-clock output coming back from the counter
//   d, load_n, cten_n, down_up_n    counter pins driven by the sequencer
//   busy, done                      status back to the timing control logic
// Modports:
//   master  timing control logic together with the counter it serves
//   slave   the sequencer
interface ttl191_load_sequencer_if;
    import ttl191_load_sequencer_pkg::*;

    logic                   start;
    logic [COUNT_WIDTH-1:0] count;
    logic                   dir_down;
    logic                   abort;
    logic                   rco_n;
    logic [COUNT_WIDTH-1:0] d;
    logic                   load_n;
    logic                   cten_n;
    logic                   down_up_n;
    logic                   busy;
    logic                   done;

    modport master (
        output start, count, dir_down, abort, rco_n,
        input  d, load_n, cten_n, down_up_n, busy, done
    );

    modport slave (
        input  start, count, dir_down, abort, rco_n,
        output d, load_n, cten_n, down_up_n, busy, done
    );

endinterface

// File: rtl/ttl191_load_sequencer.sv
// ttl191_load_sequencer: loads a ttl191 counter, runs it to terminal count and reports completion
// Ports:
//   CLK      system clock, shared with the counter
//   RESET_n  asynchronous active-low reset
//   bus      slave side of ttl191_load_sequencer_if
//            in : start, count, dir_down, abort, rco_n
//            out: d, load_n, cten_n, down_up_n, busy, done (all registered)
// Run length from the START edge to DONE, counting both edges, is COUNT+3 down or
// (15-COUNT)+3 up, because RCO_n is only seen on the edge that wraps the counter.
module ttl191_load_sequencer
    import ttl191_load_sequencer_pkg::*;
(
    input logic                    CLK,
    input logic                    RESET_n,
    ttl191_load_sequencer_if.slave bus
);

    seq_state_e state;

    // Every output is a flop, so LOAD_n cannot glitch into the counter's asynchronous load.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state         <= SEQ_IDLE;
            bus.d         <= '0;
            bus.load_n    <= 1'b1;
            bus.cten_n    <= 1'b1;
            bus.down_up_n <= DIR_UP;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    // START wins over a simultaneous ABORT here.
                    if (bus.start) begin
                        state         <= SEQ_LOAD;
                        bus.d         <= bus.count;
                        bus.down_up_n <= bus.dir_down;
                        bus.busy      <= 1'b1;
                        bus.load_n    <= 1'b0;
                    end
                end
                SEQ_LOAD: begin
                    state      <= bus.abort ? SEQ_IDLE : SEQ_COUNT;
                    bus.load_n <= 1'b1;
                    bus.cten_n <= bus.abort;
                    bus.busy   <= !bus.abort;
                end
                SEQ_COUNT: begin
                    // ABORT takes priority over terminal count on the same edge.
                    if (bus.abort) begin
                        state      <= SEQ_IDLE;
                        bus.cten_n <= 1'b1;
                        bus.busy   <= 1'b0;
                    end else if (!bus.rco_n) begin
                        state      <= SEQ_DONE;
                        bus.cten_n <= 1'b1;
                        bus.done   <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    state    <= SEQ_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state         <= SEQ_IDLE;
                    bus.d         <= '0;
                    bus.load_n    <= 1'b1;
                    bus.cten_n    <= 1'b1;
                    bus.down_up_n <= DIR_UP;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttl191_load_sequencer.sv
// tb_ttl191_load_sequencer: sequencer driving a behavioural 191 counter, checked against run-length arithmetic
module tb_ttl191_load_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic [3:0] q = 4'h0;
    int         total = 0;
    int         passed = 0;

    ttl191_load_sequencer_if bus ();

    ttl191_load_sequencer dut (
        .CLK    (CLK),
        .RESET_n(RESET_n),
        .bus    (bus)
    );

    always #10 CLK = ~CLK;

    // 191 counter: asynchronous parallel load, counts when CTEN_n is low.
    always @(posedge CLK or negedge bus.load_n)
        if (!bus.load_n) q <= bus.d;
        else if (!bus.cten_n) q <= bus.down_up_n ? q - 4'd1 : q + 4'd1;

    assign bus.rco_n = !(!bus.cten_n && q == (bus.down_up_n ? 4'h0 : 4'hF));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ab: 0 = no abort, -1 = abort together with START, n>0 = abort sampled on edge n after START.
    // poke: raise START again while busy, with a different COUNT.
    task automatic run(input logic [3:0] c, input logic dn, input int ab, input logic poke);
        int         len, de, pulses, bc;
        logic [3:0] qe;
        len = dn ? int'(c) + 3 : 18 - int'(c);
        @(negedge CLK);
        bus.start = 1'b1;
        bus.count = c;
        bus.dir_down = dn;
        bus.abort = (ab < 0);
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("load_n_low", 32'(bus.load_n), 0);
        chk("busy_set", 32'(bus.busy), 1);
        chk("d_latched", 32'(bus.d), 32'(c));
        chk("dir_latched", 32'(bus.down_up_n), 32'(dn));
        de = -1;
        pulses = 0;
        bc = 1;
        for (int i = 1; i <= len + 1; i++) begin
            bus.abort = (i == ab);
            bus.start = poke && i == 2 && ab != 1;
            bus.count = ~c;
            @(posedge CLK);
            @(negedge CLK);
            if (bus.done) begin
                pulses++;
                if (de < 0) de = i;
            end
            if (bus.busy) bc++;
            if (i == 1) chk("load_one_cycle", 32'(bus.load_n), 1);
            if (i == ab) chk("abort_busy", 32'(bus.busy), 0);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("busy_clear", 32'(bus.busy), 0);
        chk("cten_off", 32'(bus.cten_n), 1);
        chk("d_hold", 32'(bus.d), 32'(c));
        if (ab > 0) begin
            qe = ab == 1 ? c : (dn ? c - 4'(ab - 1) : c + 4'(ab - 1));
            chk("abort_no_done", 32'(pulses), 0);
            chk("abort_busy_cycles", 32'(bc), 32'(ab));
        end else begin
            qe = dn ? 4'hF : 4'h0;
            chk("done_edge", 32'(de), 32'(len - 1));
            chk("done_width", 32'(pulses), 1);
            chk("busy_cycles", 32'(bc), 32'(len));
        end
        chk("q_final", 32'(q), 32'(qe));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_d"}, 32'(bus.d), 0);
        chk({tag, "_load_n"}, 32'(bus.load_n), 1);
        chk({tag, "_cten_n"}, 32'(bus.cten_n), 1);
        chk({tag, "_dir"}, 32'(bus.down_up_n), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.count = 4'h0;
        bus.dir_down = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(posedge CLK);
        #1 chk_reset_vals("reset");
        @(negedge CLK);
        RESET_n = 1'b1;
        run(4'h5, 1'b1, 0, 1'b0);
        run(4'hD, 1'b0, 0, 1'b0);
        run(4'h0, 1'b1, 0, 1'b0);
        run(4'h8, 1'b1, 4, 1'b0);
        run(4'hF, 1'b0, 0, 1'b1);
        run(4'h7, 1'b0, -1, 1'b1);
        run(4'h9, 1'b0, 1, 1'b0);
        @(negedge CLK);
        bus.abort = 1'b1;
        repeat (2) @(negedge CLK);
        bus.abort = 1'b0;
        chk("idle_abort_busy", 32'(bus.busy), 0);
        chk("idle_abort_load", 32'(bus.load_n), 1);
        @(negedge CLK);
        bus.start = 1'b1;
        bus.count = 4'hA;
        bus.dir_down = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RESET_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(posedge CLK);
        #1 chk("midrst_held_busy", 32'(bus.busy), 0);
        #2 RESET_n = 1'b1;
        run(4'h3, 1'b0, 0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            logic [3:0] c;
            logic       dn;
            int         l, ab;
            c = 4'($urandom_range(0, 15));
            dn = 1'($urandom_range(0, 1));
            l = dn ? int'(c) + 3 : 18 - int'(c);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, l - 1)) : 0;
            run(c, dn, ab, 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
